// File: rtl/movie_table_pkg.sv
// movie_table_pkg: op codes, record field slices and FSM state encoding shared by the
// movie record store and its downstream read buffer.
package movie_table_pkg;
  localparam int DATA_W = 46;
  localparam int ID_W   = 6;
  localparam logic [2:0] OP_NEW          = 3'b000;
  localparam logic [2:0] OP_READ_BY_ID   = 3'b001;
  localparam logic [2:0] OP_CHANGE_BY_ID = 3'b010;
  localparam logic [2:0] OP_DELETE_BY_ID = 3'b011;
  localparam logic [2:0] OP_READ_ALL     = 3'b100;
  localparam logic [2:0] OP_CLEAR_ALL    = 3'b101;
  localparam logic [2:0] OP_IDLE         = 3'b111;
  localparam int ID_HI      = 45;
  localparam int ID_LO      = 40;
  localparam int NAME_HI    = 39;
  localparam int NAME_LO    = 35;
  localparam int PRICE_HI   = 34;
  localparam int PRICE_LO   = 25;
  localparam int SESSION_HI = 24;
  localparam int SESSION_LO = 10;
  localparam int REST_HI    = 9;
  localparam int REST_LO    = 5;
  localparam int SEAT_HI    = 4;
  localparam int SEAT_LO    = 1;
  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_SCAN = 2'd1;
  localparam state_t S_DONE = 2'd2;
endpackage

// File: rtl/movie_table_if.sv
// movie_table_if: operation request and result bus of the movie record store.
interface movie_table_if;
  import movie_table_pkg::*;
  logic [2:0]        op_i;
  logic [ID_W-1:0]   id_i;
  logic [DATA_W-1:0] data_i;
  logic              busy_o;
  logic              over_o;
  logic              wrong_o;
  logic              rd_valid_o;
  logic [5:0]        n_o;
  logic [DATA_W-1:0] data_o;
  logic [6:0]        count_o;
  modport master (
    output op_i, id_i, data_i,
    input  busy_o, over_o, wrong_o, rd_valid_o, n_o, data_o, count_o
  );
  modport slave (
    input  op_i, id_i, data_i,
    output busy_o, over_o, wrong_o, rd_valid_o, n_o, data_o, count_o
  );
endinterface

// File: rtl/movie_table.sv
// movie_table: linear-scan movie record store (new, read/change/delete by id, read_all, clear_all).
// Define MOVIE_TABLE_DUP_CHECK_EN to make new scan every slot and reject duplicate ids.
module movie_table
  import movie_table_pkg::*;
#(
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst_n,
  movie_table_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  state_t            r_state;
  logic [2:0]        r_op;
  logic [ID_W-1:0]   r_id;
  logic [DATA_W-1:0] r_din;
  logic [DATA_W-1:0] r_dout;
  logic [PW-1:0]     r_ptr;
  logic [DEPTH-1:0]  r_valid;
  logic [6:0]        r_count;
  logic [5:0]        r_idx;
  logic [5:0]        r_n;
  logic              r_wrong;
  logic              r_rdv;
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_scan, w_last, w_vld, w_hit, w_new_go, w_new_ok;
  logic              w_go, w_ok, w_we, w_stream, w_over;
  logic [PW-1:0]     w_new_slot, w_slot;
  logic [DATA_W-1:0] w_rec;
  assign w_scan = r_state == S_SCAN;
  assign w_last = r_ptr == PW'(DEPTH - 1);
  assign w_rec  = r_mem[r_ptr];
  assign w_vld  = r_valid[r_ptr];
  assign w_hit  = w_vld && w_rec[ID_HI:ID_LO] == r_id;
`ifdef MOVIE_TABLE_DUP_CHECK_EN
  logic          r_dup, r_fnd, w_dup_n, w_fnd_n;
  logic [PW-1:0] r_fslot;
  assign w_dup_n    = r_dup || (w_vld && w_rec[ID_HI:ID_LO] == r_din[ID_HI:ID_LO]);
  assign w_fnd_n    = r_fnd || !w_vld;
  assign w_new_slot = r_fnd ? r_fslot : r_ptr;
  assign w_new_go   = w_last;
  assign w_new_ok   = !w_dup_n && w_fnd_n;
  // duplicate / lowest-free-slot accumulators over the whole scan
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_dup   <= 1'b0;
      r_fnd   <= 1'b0;
      r_fslot <= '0;
    end else if (!w_scan) begin
      r_dup   <= 1'b0;
      r_fnd   <= 1'b0;
      r_fslot <= '0;
    end else begin
      r_dup   <= w_dup_n;
      r_fnd   <= w_fnd_n;
      r_fslot <= w_new_slot;
    end
`else
  assign w_new_slot = r_ptr;
  assign w_new_go   = !w_vld || w_last;
  assign w_new_ok   = !w_vld;
`endif
  assign w_go     = r_op == OP_NEW ? w_new_go : r_op == OP_READ_ALL ? w_last : w_hit || w_last;
  assign w_ok     = r_op == OP_NEW ? w_new_ok : r_op == OP_READ_ALL || w_hit;
  assign w_slot   = r_op == OP_NEW ? w_new_slot : r_ptr;
  assign w_we     = w_scan && w_go && w_ok && (r_op == OP_NEW || r_op == OP_CHANGE_BY_ID);
  assign w_stream = w_scan && r_op == OP_READ_ALL && w_vld;
  assign w_over   = r_state == S_DONE;
  always_ff @(posedge clk)
    if (w_we) r_mem[w_slot] <= r_op == OP_CHANGE_BY_ID ? {r_id, r_din[ID_LO-1:0]} : r_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_op    <= OP_IDLE;
      r_id    <= '0;
      r_din   <= '0;
      r_dout  <= '0;
      r_ptr   <= '0;
      r_valid <= '0;
      r_count <= '0;
      r_idx   <= '0;
      r_n     <= '0;
      r_wrong <= 1'b0;
      r_rdv   <= 1'b0;
    end else if (r_state == S_IDLE) begin
      if (bus.op_i != OP_IDLE) begin
        r_op    <= bus.op_i;
        r_id    <= bus.id_i;
        r_din   <= bus.data_i;
        r_dout  <= '0;
        r_ptr   <= '0;
        r_idx   <= '0;
        r_n     <= '0;
        r_rdv   <= 1'b0;
        r_wrong <= 1'b0;
        r_state <= S_SCAN;
        if (bus.op_i == OP_CLEAR_ALL) begin
          r_valid <= '0;
          r_count <= '0;
          r_state <= S_DONE;
        end else if (bus.op_i > OP_CLEAR_ALL || (bus.op_i == OP_NEW && r_count == 7'(DEPTH))) begin
          r_wrong <= 1'b1;
          r_state <= S_DONE;
        end
      end
    end else if (w_scan) begin
      r_ptr <= r_ptr + 1'b1;
      if (w_stream) r_idx <= r_idx + 6'd1;
      if (w_go) begin
        r_state <= S_DONE;
        r_wrong <= !w_ok;
        if (w_ok && r_op != OP_READ_ALL) r_n <= 6'(w_slot);
        if (w_ok && r_op == OP_READ_BY_ID) begin
          r_rdv  <= 1'b1;
          r_dout <= w_rec;
        end
        if (w_ok && r_op == OP_DELETE_BY_ID) begin
          r_valid[r_ptr] <= 1'b0;
          r_count        <= r_count - 7'd1;
        end
        if (w_ok && r_op == OP_NEW) begin
          r_valid[w_new_slot] <= 1'b1;
          r_count             <= r_count + 7'd1;
        end
      end
    end else begin
      r_state <= S_IDLE;
    end
  assign bus.busy_o     = r_state != S_IDLE;
  assign bus.over_o     = w_over;
  assign bus.wrong_o    = w_over && r_wrong;
  assign bus.rd_valid_o = w_stream || (w_over && r_rdv);
  assign bus.n_o        = w_stream ? r_idx : w_over ? r_n : '0;
  assign bus.data_o     = w_stream ? w_rec : (w_over && r_rdv) ? r_dout : '0;
  assign bus.count_o    = r_count;
endmodule

// File: tb/tb_movie_table.sv
// tb_movie_table: directed and random operations against an array-based model of the record store.
module tb_movie_table;
  import movie_table_pkg::*;
  localparam int DEPTH = 64;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  logic [45:0] m_rec [DEPTH];
  bit          m_v [DEPTH];
  int          m_cnt = 0;
  movie_table_if bus();
  movie_table #(.DEPTH(DEPTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) m_v[i] = 0;
    m_cnt = 0;
  endtask
  task automatic do_op(input logic [2:0] op, input logic [5:0] id, input logic [45:0] d);
    logic [45:0] eq[$];
    logic [5:0]  en[$];
    logic [45:0] gq[$];
    logic [5:0]  gn[$];
    int k, exp_cyc, cyc;
    bit exp_wrong, chk_n, got_wrong;
    logic [5:0] exp_n, got_n;
    logic [6:0] got_cnt;
`ifdef MOVIE_TABLE_DUP_CHECK_EN
    bit dup;
`endif
    exp_wrong = 0; chk_n = 0; exp_n = 0; exp_cyc = 1; k = -1;
    got_wrong = 0; got_n = 0; got_cnt = 0; cyc = 0;
    if (op == OP_READ_BY_ID || op == OP_CHANGE_BY_ID || op == OP_DELETE_BY_ID) begin
      for (int i = 0; i < DEPTH; i++) if (k < 0 && m_v[i] && m_rec[i][45:40] == id) k = i;
      if (k < 0) begin
        exp_wrong = 1;
        exp_cyc = DEPTH + 1;
      end else begin
        exp_cyc = k + 2;
        chk_n = 1;
        exp_n = 6'(k);
        if (op == OP_READ_BY_ID) begin
          eq.push_back(m_rec[k]);
          en.push_back(6'(k));
        end
        if (op == OP_CHANGE_BY_ID) m_rec[k] = {id, d[39:0]};
        if (op == OP_DELETE_BY_ID) begin
          m_v[k] = 0;
          m_cnt--;
        end
      end
    end else if (op == OP_NEW) begin
      if (m_cnt == DEPTH) exp_wrong = 1;
      else begin
        for (int i = 0; i < DEPTH; i++) if (k < 0 && !m_v[i]) k = i;
`ifdef MOVIE_TABLE_DUP_CHECK_EN
        dup = 0;
        for (int i = 0; i < DEPTH; i++) if (m_v[i] && m_rec[i][45:40] == d[45:40]) dup = 1;
        exp_cyc = DEPTH + 1;
        exp_wrong = dup;
`else
        exp_cyc = k + 2;
`endif
        if (!exp_wrong) begin
          chk_n = 1;
          exp_n = 6'(k);
          m_rec[k] = d;
          m_v[k] = 1;
          m_cnt++;
        end
      end
    end else if (op == OP_READ_ALL) begin
      exp_cyc = DEPTH + 1;
      for (int i = 0; i < DEPTH; i++) if (m_v[i]) begin
        en.push_back(6'(eq.size()));
        eq.push_back(m_rec[i]);
      end
    end else if (op == OP_CLEAR_ALL) model_clear();
    else exp_wrong = 1;
    @(negedge clk);
    bus.op_i = op; bus.id_i = id; bus.data_i = d;
    @(posedge clk);
    #1 bus.op_i = OP_IDLE;
    for (int c = 1; c <= 200 && cyc == 0; c++) begin
      @(negedge clk);
      if (c == 1) check("busy", bus.busy_o, 1);
      if (bus.rd_valid_o) begin
        gq.push_back(bus.data_o);
        gn.push_back(bus.n_o);
      end
      if (bus.over_o) begin
        cyc = c;
        got_wrong = bus.wrong_o;
        got_n = bus.n_o;
        got_cnt = bus.count_o;
      end
    end
    check($sformatf("over_cyc op%0d", op), cyc, exp_cyc);
    check($sformatf("wrong op%0d", op), got_wrong, exp_wrong);
    if (chk_n) check($sformatf("n op%0d", op), got_n, exp_n);
    check($sformatf("count op%0d", op), got_cnt, m_cnt);
    check($sformatf("rd_num op%0d", op), gq.size(), eq.size());
    for (int i = 0; i < gq.size() && i < eq.size(); i++) begin
      check("rd_n", gn[i], en[i]);
      check("rd_data", gq[i], eq[i]);
    end
  endtask
  function automatic logic [45:0] rec(input int id);
    return {6'(id), $urandom(), 8'($urandom())};
  endfunction
  initial begin
    int r;
    logic [5:0] rid;
    bus.op_i = OP_IDLE; bus.id_i = '0; bus.data_i = '0;
    model_clear();
    repeat (3) @(negedge clk);
    check("rst_busy", bus.busy_o, 0);
    check("rst_over", bus.over_o, 0);
    check("rst_rdv", bus.rd_valid_o, 0);
    check("rst_count", bus.count_o, 0);
    rst_n = 1'b1;
    do_op(OP_NEW, 6'd5, {6'd5, 40'h1});
    do_op(OP_DELETE_BY_ID, 6'd5, '0);
    do_op(OP_NEW, 6'd0, rec(1));
    do_op(OP_NEW, 6'd0, rec(2));
    do_op(OP_NEW, 6'd0, rec(3));
    do_op(OP_DELETE_BY_ID, 6'd2, '0);
    do_op(OP_READ_ALL, 6'd0, '0);
    do_op(OP_READ_BY_ID, 6'd9, '0);
    do_op(OP_READ_BY_ID, 6'd3, '0);
    do_op(OP_CHANGE_BY_ID, 6'd3, rec(60));
    do_op(OP_READ_BY_ID, 6'd3, '0);
    do_op(3'b110, 6'd0, '0);
    do_op(OP_CLEAR_ALL, 6'd0, '0);
    for (int i = 0; i < DEPTH; i++) do_op(OP_NEW, 6'd0, rec(i));
    do_op(OP_NEW, 6'd0, rec(7));
    do_op(OP_READ_BY_ID, 6'd63, '0);
    do_op(OP_CLEAR_ALL, 6'd0, '0);
    do_op(OP_NEW, 6'd0, rec(4));
    do_op(OP_NEW, 6'd0, rec(4));
    do_op(OP_NEW, 6'd0, rec(1));
    // abort a read_all with reset in its tenth cycle
    @(negedge clk);
    bus.op_i = OP_READ_ALL;
    @(posedge clk);
    #1 bus.op_i = OP_IDLE;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", bus.busy_o, 0);
    check("arst_over", bus.over_o, 0);
    check("arst_wrong", bus.wrong_o, 0);
    check("arst_rdv", bus.rd_valid_o, 0);
    check("arst_n", bus.n_o, 0);
    check("arst_data", bus.data_o, 0);
    check("arst_count", bus.count_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    @(negedge clk);
    check("post_rst_over", bus.over_o, 0);
    check("post_rst_count", bus.count_o, 0);
    do_op(OP_READ_ALL, 6'd0, '0);
    for (int t = 0; t < 200; t++) begin
      r = $urandom_range(0, 19);
      rid = 6'($urandom_range(0, 9));
      if (r <= 6) do_op(OP_NEW, 6'd0, rec($urandom_range(0, 9)));
      else if (r <= 9 || r >= 18) do_op(OP_READ_BY_ID, rid, '0);
      else if (r <= 11) do_op(OP_CHANGE_BY_ID, rid, rec($urandom_range(0, 63)));
      else if (r <= 14) do_op(OP_DELETE_BY_ID, rid, '0);
      else if (r == 15) do_op(OP_READ_ALL, 6'd0, '0);
      else if (r == 16) do_op(OP_CLEAR_ALL, 6'd0, '0);
      else do_op(3'b110, rid, '0);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
